// File: rtl/sm3_pad_arbiter_pkg.sv
// Shared types and helpers for the SM3 pad-core round-robin arbiter.
package sm3_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int unsigned N_CH_MAX = 8;
  localparam int unsigned PICK_W   = 3;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Channels above N_CH are fed in as zero, so wrapping over N_CH_MAX
  // gives the same search order as wrapping over N_CH.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [N_CH_MAX-1:0] vld,
                                                input logic [PICK_W-1:0]   ptr);
    logic [PICK_W-1:0] idx;
    logic [PICK_W-1:0] pick;
    logic              found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CH_MAX; i++) begin
      idx = ptr + PICK_W'(i);
      if (!found && vld[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sm3_pad_arbiter_if.sv
// Requester-side, pad-core-side and status signals of the SM3 pad arbiter.
interface sm3_pad_arbiter_if
  import sm3_arb_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned BW   = DW / 8
) ();
  localparam int unsigned CH_W = ch_w(N_CH);

  logic [N_CH*DW-1:0] req_d_i;
  logic [N_CH*BW-1:0] req_vld_byte_i;
  logic [N_CH-1:0]    req_vld_i;
  logic [N_CH-1:0]    req_lst_i;
  logic [N_CH-1:0]    req_rdy_o;
  logic [DW-1:0]      msg_inpt_d_o;
  logic [BW-1:0]      msg_inpt_vld_byte_o;
  logic               msg_inpt_vld_o;
  logic               msg_inpt_lst_o;
  logic               msg_inpt_rdy_i;
  logic               pad_otpt_vld_i;
  logic               pad_otpt_lst_i;
  logic [CH_W-1:0]    otpt_ch_o;
  logic               otpt_ch_vld_o;
  logic               busy_o;
  logic               err_o;

  modport slave (
    input  req_d_i, req_vld_byte_i, req_vld_i, req_lst_i,
    input  msg_inpt_rdy_i, pad_otpt_vld_i, pad_otpt_lst_i,
    output req_rdy_o, msg_inpt_d_o, msg_inpt_vld_byte_o, msg_inpt_vld_o,
    output msg_inpt_lst_o, otpt_ch_o, otpt_ch_vld_o, busy_o, err_o
  );

  modport master (
    output req_d_i, req_vld_byte_i, req_vld_i, req_lst_i,
    output msg_inpt_rdy_i, pad_otpt_vld_i, pad_otpt_lst_i,
    input  req_rdy_o, msg_inpt_d_o, msg_inpt_vld_byte_o, msg_inpt_vld_o,
    input  msg_inpt_lst_o, otpt_ch_o, otpt_ch_vld_o, busy_o, err_o
  );
endinterface

// File: rtl/sm3_tag_fifo.sv
// Small synchronous FIFO of channel tags for messages in flight in the pad core.
module sm3_tag_fifo
  import sm3_arb_pkg::*;
#(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int unsigned PW = ch_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) begin
      rd_d = ptr_inc(rd_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sm3_pad_arbiter.sv
// Round-robin, whole-message arbiter sharing one SM3 pad core among N_CH sources;
// tags each granted message so pad-core output streams can be attributed.
module sm3_pad_arbiter
  import sm3_arb_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned BW        = DW / 8,
  parameter int unsigned TAG_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  sm3_pad_arbiter_if.slave  bus
);
  localparam int unsigned CH_W = ch_w(N_CH);

  arb_state_e      state_q, state_d;
  logic [CH_W-1:0] gnt_q, gnt_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic            err_q, err_d;
  logic [CH_W-1:0] pick;
  logic            push, pop_req, fifo_full, fifo_empty;
  logic [CH_W-1:0] head;
  logic [N_CH-1:0] req_rdy;
  logic [DW-1:0]   sel_d;
  logic [BW-1:0]   sel_byte;
  logic            sel_vld, sel_lst;

  assign pick    = CH_W'(rr_pick(N_CH_MAX'(bus.req_vld_i), PICK_W'(rr_q)));
  assign pop_req = bus.pad_otpt_vld_i && bus.pad_otpt_lst_i;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    push     = 1'b0;
    req_rdy  = '0;
    sel_d    = '0;
    sel_byte = '0;
    sel_vld  = 1'b0;
    sel_lst  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|bus.req_vld_i && !fifo_full) begin
          gnt_d   = pick;
          push    = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        sel_d          = bus.req_d_i[gnt_q*DW +: DW];
        sel_byte       = bus.req_vld_byte_i[gnt_q*BW +: BW];
        sel_vld        = bus.req_vld_i[gnt_q];
        sel_lst        = bus.req_lst_i[gnt_q];
        req_rdy[gnt_q] = bus.msg_inpt_rdy_i;
        if (sel_vld && bus.msg_inpt_rdy_i && sel_lst) begin
          rr_d    = (gnt_q == CH_W'(N_CH - 1)) ? '0 : gnt_q + 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    err_d = err_q | (pop_req & fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  sm3_tag_fifo #(
    .W     (CH_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (pick),
    .pop   (pop_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign bus.req_rdy_o           = req_rdy;
  assign bus.msg_inpt_d_o        = sel_d;
  assign bus.msg_inpt_vld_byte_o = sel_byte;
  assign bus.msg_inpt_vld_o      = sel_vld;
  assign bus.msg_inpt_lst_o      = sel_lst;
  assign bus.otpt_ch_o           = fifo_empty ? '0 : head;
  assign bus.otpt_ch_vld_o       = !fifo_empty;
  assign bus.busy_o              = (state_q == ARB_BUSY);
  assign bus.err_o               = err_q;
endmodule

// File: doc/sm3_pad_arbiter.md
# sm3_pad_arbiter

Round-robin arbiter that shares one `sm3_pad_core` between `N_CH` independent message sources. It grants one whole message at a time, locking the grant from the first accepted beat to the beat carrying `msg_inpt_lst`. It records which channel owns each message in flight, so downstream logic can attribute every padded block stream on `pad_otpt_*` to its source channel. It sits between the requester-side message buses and the PAD-side `sm3_if` inputs.

## Interface
- `N_CH`, default 4: number of requesting channels; range 2..8.
- `DW`, default 32: message data width, 32 or 64, matching the `sm3_cfg` build.
- `BW`, default `DW/8`: byte-valid width.
- `TAG_DEPTH`, default 2: number of messages allowed in flight inside the pad core.
- `clk`, input, 1: single clock; every flop is on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_d_i`, input, `N_CH*DW`: per-channel message data.
- `req_vld_byte_i`, input, `N_CH*BW`: per-channel byte-valid mask.
- `req_vld_i`, input, `N_CH`: per-channel beat valid.
- `req_lst_i`, input, `N_CH`: per-channel last beat of message.
- `req_rdy_o`, output, `N_CH`: per-channel beat accepted.
- `msg_inpt_d_o`, output, `DW`: to the pad core.
- `msg_inpt_vld_byte_o`, output, `BW`: to the pad core.
- `msg_inpt_vld_o`, output, 1: to the pad core.
- `msg_inpt_lst_o`, output, 1: to the pad core.
- `msg_inpt_rdy_i`, input, 1: ready from the pad core.
- `pad_otpt_vld_i`, input, 1: observed pad core output valid.
- `pad_otpt_lst_i`, input, 1: observed pad core output last.
- `otpt_ch_o`, output, `$clog2(N_CH)`: owner channel of the current pad output stream.
- `otpt_ch_vld_o`, output, 1: tag FIFO is non-empty, so `otpt_ch_o` is meaningful.
- `busy_o`, output, 1: a grant is currently locked.
- `err_o`, output, 1: sticky flag; a pad output last arrived while the tag FIFO was empty.

## Operation
- **IDLE state**
  - If any `req_vld_i` bit is set and the tag FIFO is not full, pick a channel `g`.
  - The pick is the first channel with valid set, searching from `rr_ptr` upward with wrap-around.
  - On the same edge: register `g`, push `g` into the tag FIFO, and go to BUSY.
  - No channel sees ready in IDLE.
- **BUSY state**
  - `msg_inpt_*_o` equal channel `g`'s inputs (combinational mux).
  - `req_rdy_o[g] = msg_inpt_rdy_i`; all other `req_rdy_o` bits are 0.
  - When `vld && rdy && lst` on the selected channel: set `rr_ptr <= g+1` (mod `N_CH`) and go to IDLE.
  - `g` may deassert valid mid-message. The grant holds and no other channel is serviced.
- **Tag FIFO**
  - Pushed at each grant.
  - Popped when `pad_otpt_vld_i && pad_otpt_lst_i`.
  - `otpt_ch_o` shows the FIFO head.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - A pop while empty is ignored, and `err_o` is set until reset.
- **Full FIFO:** with `TAG_DEPTH` messages in flight, IDLE does not grant. All channels stall until a pop.
- **Single-beat message** (`lst` on the first beat): legal, giving IDLE → BUSY → IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, `rr_ptr=0`, FIFO empty, `err_o=0`.
- **Reset mid-message:** the message is discarded. No partial state survives, and the pad core must be reset together with this block.
- **Arbitration latency:** 1 cycle from valid seen in IDLE to the first possible beat in BUSY.
- **Inter-message bubble:** exactly 1 IDLE cycle after each `lst` beat.
- **Data path:** zero latency; there is no registering on `msg_inpt_*` in BUSY.
- **`busy_o`:** equals (state == BUSY), registered.
- **`otpt_ch_o`:** changes on the edge after the pop, to the next head.

## Structure
- **Package `sm3_arb_pkg`:**
  - state enum `{ARB_IDLE, ARB_BUSY}`;
  - `CH_W = $clog2(N_CH)` helper;
  - round-robin priority-pick function `rr_pick(vld, ptr)`.
- **Sub-module `sm3_tag_fifo`:**
  - synchronous FIFO, width `CH_W`, depth `TAG_DEPTH`;
  - ports: push, pop, full, empty, head;
  - asynchronous active-high reset.
- The top level contains the FSM, the grant register, `rr_ptr`, the output muxes and `err_o`.

## Test plan
- **Reset:** assert `rst` mid-BUSY → all outputs 0 within the same cycle; after release, channel 0 has first priority.
- **Round-robin:** all 4 channels hold 3-beat messages valid → grant order 0,1,2,3,0; each message 3 beats plus 1 bubble; `req_rdy_o` one-hot matching the grant.
- **Lock:** channel 2 drops valid for 5 cycles mid-message while channel 1 is valid → no beats from channel 1 until channel 2's `lst` beat.
- **FIFO full:** `TAG_DEPTH=2`, `pad_otpt_lst` withheld, 3 messages requested → third grant waits; it is granted 1 cycle after a pad output last arrives. `otpt_ch_o` shows 0 then 1.
- **Simultaneous push and pop:** grant coincides with pad output last → occupancy unchanged; head advances correctly.
- **Error path:** pad output last with FIFO empty → `err_o=1` and stays set; FIFO stays empty.
